// File: rtl/mips_multicycle_control_if.sv
// Signal bundle between the multicycle control FSM and the datapath/memory side.
// The master modport is the control unit; the slave modport is the datapath.
interface mips_multicycle_control_if #(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 3
);
    logic [5:0]         i_opcode;
    logic [5:0]         i_funcode;
    logic               i_zero;
    logic               i_mem_ready;
    logic               o_mem_read;
    logic               o_mem_write;
    logic               o_i_or_d;
    logic               o_ir_write;
    logic               o_pc_en;
    logic [1:0]         o_pc_source;
    logic               o_reg_write;
    logic               o_reg_dst;
    logic               o_mem_to_reg;
    logic               o_alu_src_a;
    logic [1:0]         o_alu_src_b;
    logic [ALUOP_W-1:0] o_alu_op;
    logic               o_ext_zero;
    logic               o_halted;
    logic [3:0]         o_state;
    logic [CNT_W-1:0]   o_cycle_count;
    logic [CNT_W-1:0]   o_instr_count;

    modport master (
        input  i_opcode, i_funcode, i_zero, i_mem_ready,
        output o_mem_read, o_mem_write, o_i_or_d, o_ir_write, o_pc_en, o_pc_source,
               o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
               o_alu_op, o_ext_zero, o_halted, o_state, o_cycle_count, o_instr_count
    );

    modport slave (
        output i_opcode, i_funcode, i_zero, i_mem_ready,
        input  o_mem_read, o_mem_write, o_i_or_d, o_ir_write, o_pc_en, o_pc_source,
               o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
               o_alu_op, o_ext_zero, o_halted, o_state, o_cycle_count, o_instr_count
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and counts cycles and retired instructions.
module mips_multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 3
) (
    input logic                        i_clock,
    input logic                        i_reset,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   r_instr_count;
    logic               w_retire;

    logic               w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_en;
    logic [1:0]         w_pc_source;
    logic               w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [ALUOP_W-1:0] w_alu_op;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_FETCH;
        else         r_state <= w_next;
    end

    // An instruction retires on the edge that returns the FSM to FETCH.
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_I_WB});

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 1'b1;
            if (w_retire)          r_instr_count <= r_instr_count + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_i_or_d     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_en      = 1'b0;
        w_pc_source  = 2'b00;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = ALU_ADD;
        unique case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.i_mem_ready;
                w_pc_en     = bus.i_mem_ready;
                if (bus.i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (bus.i_opcode)
                    OP_RTYPE:                           w_next = S_R_EXEC;
                    OP_LW, OP_SW:                       w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     w_next = S_BRANCH;
                    OP_J:                               w_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  w_next = S_I_EXEC;
                    default:                            w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (bus.i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.i_mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.i_mem_ready) w_next = S_FETCH;
            end
            S_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_FUNC;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_SUB;
                w_pc_source = 2'b01;
                w_pc_en     = (bus.i_opcode == OP_BNE) ? ~bus.i_zero : bus.i_zero;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_source = 2'b10;
                w_pc_en     = 1'b1;
                w_next      = S_FETCH;
            end
            S_I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                case (bus.i_opcode)
                    OP_ANDI: w_alu_op = ALU_AND;
                    OP_ORI:  w_alu_op = ALU_OR;
                    OP_SLTI: w_alu_op = ALU_SLT;
                    default: w_alu_op = ALU_ADD;
                endcase
                w_next = S_I_WB;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
    end

    // Reset is asynchronous, so strobes are masked combinationally while it is held.
    assign bus.o_mem_read    = w_mem_read  & ~i_reset;
    assign bus.o_mem_write   = w_mem_write & ~i_reset;
    assign bus.o_ir_write    = w_ir_write  & ~i_reset;
    assign bus.o_pc_en       = w_pc_en     & ~i_reset;
    assign bus.o_reg_write   = w_reg_write & ~i_reset;
    assign bus.o_i_or_d      = w_i_or_d;
    assign bus.o_pc_source   = w_pc_source;
    assign bus.o_reg_dst     = w_reg_dst;
    assign bus.o_mem_to_reg  = w_mem_to_reg;
    assign bus.o_alu_src_a   = w_alu_src_a;
    assign bus.o_alu_src_b   = w_alu_src_b;
    assign bus.o_alu_op      = w_alu_op;
    assign bus.o_ext_zero    = (bus.i_opcode == OP_ANDI) || (bus.i_opcode == OP_ORI);
    assign bus.o_halted      = (r_state == S_HALT);
    assign bus.o_state       = r_state;
    assign bus.o_cycle_count = r_cycle_count;
    assign bus.o_instr_count = r_instr_count;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Random instruction stream against a per-cycle expectation queue; a monitor
// compares every observed cycle against the planned expectation.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_multicycle_control_if #(.CNT_W(4), .ALUOP_W(3)) bus ();
    mips_multicycle_control #(.CNT_W(4), .ALUOP_W(3)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mr, mw, iod, irw, pce;
        logic [1:0] pcs;
        logic       rw, rd, m2r, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic       ez, hlt;
        logic [3:0] cc, ic;
    } obs_t;

    obs_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [5:0] m_op  = 6'd0;
    logic       m_zero = 1'b0;
    logic       m_rst  = 1'b1;
    int         m_cyc  = 0;
    int         m_ins  = 0;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected outputs for one cycle spent in phase st.
    function automatic obs_t exp_out(input int st, input logic rdy);
        obs_t o = '0;
        o.st = 4'(st);
        o.ez = (m_op == 6'b001100) || (m_op == 6'b001101);
        o.cc = 4'(m_cyc);
        o.ic = 4'(m_ins);
        case (st)
            0:  begin o.mr = 1; o.asb = 2'b01; o.irw = rdy; o.pce = rdy; end
            1:  o.asb = 2'b11;
            2:  begin o.asa = 1; o.asb = 2'b10; end
            3:  begin o.mr = 1; o.iod = 1; end
            4:  begin o.rw = 1; o.m2r = 1; end
            5:  begin o.mw = 1; o.iod = 1; end
            6:  begin o.asa = 1; o.aop = 3'd2; end
            7:  begin o.rw = 1; o.rd = 1; end
            8:  begin o.asa = 1; o.aop = 3'd1; o.pcs = 2'b01;
                      o.pce = (m_op == 6'b000100) ? m_zero : ~m_zero; end
            9:  begin o.pcs = 2'b10; o.pce = 1; end
            10: begin o.asa = 1; o.asb = 2'b10;
                      o.aop = (m_op == 6'b001100) ? 3'd3 : (m_op == 6'b001101) ? 3'd4 :
                              (m_op == 6'b001010) ? 3'd5 : 3'd0; end
            11: o.rw = 1;
            12: o.hlt = 1;
            default: ;
        endcase
        if (m_rst) begin o.mr = 0; o.mw = 0; o.irw = 0; o.pce = 0; o.rw = 0; end
        return o;
    endfunction

    task automatic step(input int st, input logic rdy, input logic retire);
        bus.i_mem_ready = rdy;
        q.push_back(exp_out(st, rdy));
        @(posedge clk); #1;
        if (!m_rst) begin
            if (st != 12) m_cyc = (m_cyc + 1) & 15;
            if (retire)   m_ins = (m_ins + 1) & 15;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; m_rst = 1'b1; m_cyc = 0; m_ins = 0;
        repeat (n) step(0, rb(), 1'b0);
        rst = 1'b0; m_rst = 1'b0;
    endtask

    task automatic start(input logic [5:0] op, input logic zero, input int fw);
        m_op = op; bus.i_opcode = op; bus.i_funcode = 6'($urandom);
        m_zero = zero; bus.i_zero = zero;
        repeat (fw) step(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        step(1, rb(), 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic zero, input int fw, input int mw);
        start(op, zero, fw);
        case (op)
            6'b000000: begin step(6, rb(), 0); step(7, rb(), 1); end
            6'b100011: begin step(2, rb(), 0); repeat (mw) step(3, 0, 0);
                             step(3, 1, 0); step(4, rb(), 1); end
            6'b101011: begin step(2, rb(), 0); repeat (mw) step(5, 0, 0); step(5, 1, 1); end
            6'b000100, 6'b000101: step(8, rb(), 1);
            6'b000010: step(9, rb(), 1);
            6'b001000, 6'b001100, 6'b001101, 6'b001010:
                       begin step(10, rb(), 0); step(11, rb(), 1); end
            default:   repeat (3) step(12, rb(), 0);
        endcase
    endtask

    // Monitor: one comparison per observed cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t e, a;
            e = q.pop_front();
            a = {bus.o_state, bus.o_mem_read, bus.o_mem_write, bus.o_i_or_d, bus.o_ir_write,
                 bus.o_pc_en, bus.o_pc_source, bus.o_reg_write, bus.o_reg_dst, bus.o_mem_to_reg,
                 bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op, bus.o_ext_zero, bus.o_halted,
                 bus.o_cycle_count, bus.o_instr_count};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle@%0t: actual=%h required=%h (st act=%0d req=%0d)",
                         $time, a, e, a.st, e.st);
            end
        end
    end

    logic [5:0] legal [10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd12, 6'd13, 6'd10};
    logic [5:0] illegal [4] = '{6'd63, 6'd1, 6'd3, 6'd15};

    initial begin
        rst = 1'b1;
        bus.i_opcode = 6'd0; bus.i_funcode = 6'd0; bus.i_zero = 1'b0; bus.i_mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset(2);
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 0, 0, 2);
        run_instr(6'b000100, 1, 1, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000101, 1, 0, 0);
        run_instr(6'b000101, 0, 2, 0);
        run_instr(6'b001101, 0, 0, 0);
        run_instr(6'b001010, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        do_reset(1);
        // Abort a store while it waits for memory.
        start(6'b101011, 0, 0);
        step(2, rb(), 0);
        step(5, 0, 0);
        do_reset(1);
        repeat (16) run_instr(6'b000010, 0, 0, 0);
        total++;
        if (bus.o_instr_count !== 4'd0) begin
            bad++;
            $display("FAIL wrap: actual=%0d required=0", bus.o_instr_count);
        end
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                run_instr(illegal[$urandom_range(0, 3)], 0, $urandom_range(0, 2), 0);
                do_reset($urandom_range(1, 2));
            end else begin
                if ($urandom_range(0, 29) == 0) do_reset(1);
                run_instr(legal[$urandom_range(0, 9)], rb(), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            end
        end
        @(negedge clk); @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d required=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
